// File: rtl/branch_predict_unit.sv
// Saturating-counter branch predictor with same-cycle branch resolution.
// Holds a PC-indexed counter table plus saturating branch and mispredict statistics.
module branch_predict_unit #(
    parameter int IDX_BITS = 4,
    parameter int CTR_BITS = 2,
    parameter int BYPASS   = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lookup_pc_i,
    output logic        predict_o,
    input  logic        Branch_i,
    input  logic        branch_result_i,
    input  logic        predict_i,
    input  logic [31:0] Imm_i,
    input  logic [31:0] PC_i,
    output logic        Flush_o,
    output logic [31:0] PC_o,
    output logic [15:0] branch_count_o,
    output logic [15:0] mispredict_count_o
);

    localparam int                  DEPTH    = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    logic [CTR_BITS-1:0] ctr_q [DEPTH];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0] upd_ctr;
    logic [CTR_BITS-1:0] upd_ctr_d;
    logic                stored_pred;
    logic                mis;
    logic                train_en;

    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mis_cnt_q, mis_cnt_d;

    // Bits outside the index (and the immediate's MSB lost by the shift) do not affect behaviour.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc_i[31:IDX_BITS+2], lookup_pc_i[1:0],
                           PC_i[1:0], Imm_i[31]};

    assign lookup_idx  = lookup_pc_i[IDX_BITS+1:2];
    assign upd_idx     = PC_i[IDX_BITS+1:2];
    assign upd_ctr     = ctr_q[upd_idx];
    assign stored_pred = ctr_q[lookup_idx][CTR_BITS-1];
    assign train_en    = Branch_i & ~rst_i;

    always_comb begin
        upd_ctr_d = upd_ctr;
        if (branch_result_i) begin
            if (upd_ctr != CTR_MAX) begin
                upd_ctr_d = upd_ctr + CTR_ONE;
            end
        end else begin
            if (upd_ctr != '0) begin
                upd_ctr_d = upd_ctr - CTR_ONE;
            end
        end
    end

    // One register per table entry so a reset can restore the whole table in a single edge.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [IDX_BITS-1:0] ENTRY_IDX = IDX_BITS'(gi);
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    ctr_q[gi] <= CTR_INIT;
                end else if (Branch_i && (upd_idx == ENTRY_IDX)) begin
                    ctr_q[gi] <= upd_ctr_d;
                end
            end
        end
    endgenerate

    generate
        if (BYPASS != 0) begin : g_bypass
            logic bypass_hit;
            assign bypass_hit = train_en & (lookup_idx == upd_idx);
            assign predict_o  = bypass_hit ? upd_ctr_d[CTR_BITS-1] : stored_pred;
        end else begin : g_no_bypass
            assign predict_o = stored_pred;
        end
    endgenerate

    assign mis     = Branch_i & (branch_result_i != predict_i);
    assign Flush_o = mis & ~rst_i;
    assign PC_o    = branch_result_i ? (PC_i + {Imm_i[30:0], 1'b0}) : (PC_i + 32'd4);

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        if (Branch_i) begin
            if (branch_cnt_q != 16'hFFFF) begin
                branch_cnt_d = branch_cnt_q + 16'd1;
            end
            if (mis && (mis_cnt_q != 16'hFFFF)) begin
                mis_cnt_d = mis_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: two instances (BYPASS=0 and BYPASS=1) share stimulus
// and are compared each cycle against an array-based reference model.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        branch;
    logic        branch_result;
    logic        predict_in;
    logic [31:0] imm;
    logic [31:0] pc;

    logic        pred0, pred1;
    logic        flush0, flush1;
    logic [31:0] pc_o0, pc_o1;
    logic [15:0] bc0, bc1, mc0, mc1;

    int n_checks = 0;
    int n_fail   = 0;

    int model_ctr [16];
    int model_bc;
    int model_mc;

    always #5 clk = ~clk;

    branch_predict_unit #(.IDX_BITS(4), .CTR_BITS(2), .BYPASS(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc), .predict_o(pred0),
        .Branch_i(branch), .branch_result_i(branch_result), .predict_i(predict_in),
        .Imm_i(imm), .PC_i(pc), .Flush_o(flush0), .PC_o(pc_o0),
        .branch_count_o(bc0), .mispredict_count_o(mc0)
    );

    branch_predict_unit #(.IDX_BITS(4), .CTR_BITS(2), .BYPASS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc), .predict_o(pred1),
        .Branch_i(branch), .branch_result_i(branch_result), .predict_i(predict_in),
        .Imm_i(imm), .PC_i(pc), .Flush_o(flush1), .PC_o(pc_o1),
        .branch_count_o(bc1), .mispredict_count_o(mc1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) model_ctr[i] = 1;
        model_bc = 0;
        model_mc = 0;
    endfunction

    // One clock cycle: entered 1 time unit after a rising edge, leaves at the same point of the next.
    task automatic do_cycle(input logic r, input logic br, input logic res, input logic pr,
                            input logic [31:0] p, input logic [31:0] im, input logic [31:0] lp,
                            input bit verbose);
        int lk, up, nv;
        logic exp_p0, exp_p1, exp_fl, mis;
        logic [31:0] exp_pc;
        rst = r; branch = br; branch_result = res; predict_in = pr;
        pc = p; imm = im; lookup_pc = lp;
        #4;
        lk     = int'(lp[5:2]);
        up     = int'(p[5:2]);
        nv     = res ? ((model_ctr[up] + 1 > 3) ? 3 : model_ctr[up] + 1)
                     : ((model_ctr[up] - 1 < 0) ? 0 : model_ctr[up] - 1);
        exp_p0 = (model_ctr[lk] >= 2);
        exp_p1 = (br && !r && lk == up) ? (nv >= 2) : exp_p0;
        mis    = br && (res != pr);
        exp_fl = mis && !r;
        exp_pc = res ? p + im * 32'd2 : p + 32'd4;
        check_val("predict_b0", 32'(pred0), 32'(exp_p0));
        check_val("predict_b1", 32'(pred1), 32'(exp_p1));
        check_val("flush_b0", 32'(flush0), 32'(exp_fl));
        check_val("flush_b1", 32'(flush1), 32'(exp_fl));
        check_val("pc_o_b0", pc_o0, exp_pc);
        check_val("pc_o_b1", pc_o1, exp_pc);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (br) begin
            model_ctr[up] = nv;
            if (model_bc < 65535) model_bc++;
            if (mis && model_mc < 65535) model_mc++;
        end
        #1;
        check_val("branch_count_b0", 32'(bc0), 32'(model_bc));
        check_val("branch_count_b1", 32'(bc1), 32'(model_bc));
        check_val("mispred_count_b0", 32'(mc0), 32'(model_mc));
        check_val("mispred_count_b1", 32'(mc1), 32'(model_mc));
        if (verbose)
            $display("txn rst=%0b br=%0b res=%0b pr=%0b pc=%08h imm=%08h lpc=%08h -> p0=%0b p1=%0b fl=%0b pco=%08h bc=%0d mc=%0d",
                     r, br, res, pr, p, im, lp, pred0, pred1, flush0, pc_o0, bc0, mc0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; branch = 1'b0; branch_result = 1'b0; predict_in = 1'b0;
        pc = '0; imm = '0; lookup_pc = 32'h40;
        @(posedge clk); #1;

        // Reset state
        do_cycle(1, 0, 0, 0, 32'h0, 32'h0, 32'h40, 1);
        do_cycle(0, 0, 0, 0, 32'h0, 32'h0, 32'h40, 1);
        // First mispredict, taken, correction to 0x50
        do_cycle(0, 1, 1, 0, 32'h40, 32'h8, 32'h40, 1);
        check_val("pc_after_first", 32'(model_ctr[0]), 32'd2);
        // Saturate up, then walk down and hold at 0
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 1, 1, 32'h40, 32'h8, 32'h40, 1);
        for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 1, 32'h40, 32'h8, 32'h40, 1);
        // PC wrap cases
        do_cycle(0, 1, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h40, 1);
        do_cycle(0, 1, 1, 0, 32'h100, 32'hFFFF_FFFC, 32'h40, 1);
        // Same-cycle read/write on index 3 (counter still at 1)
        do_cycle(0, 1, 1, 0, 32'h0C, 32'h4, 32'h0C, 1);
        // Reset with coincident mispredicting branch
        do_cycle(1, 1, 1, 0, 32'h40, 32'h8, 32'h40, 1);
        do_cycle(0, 0, 1, 0, 32'h40, 32'h8, 32'h40, 1);

        // Randomized traffic over a few PCs to exercise aliasing and bypass hits
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rp, rl;
            rp = {$urandom_range(0, 3) == 0 ? 32'($urandom) : 32'($urandom_range(0, 31)) << 2};
            rl = ($urandom_range(0, 2) == 0) ? rp : (32'($urandom_range(0, 31)) << 2);
            do_cycle(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                     rp, 32'($urandom), rl, 1);
        end

        // Statistics saturation: long run of mispredicts
        do_cycle(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
        for (int i = 0; i < 70000; i++) begin
            do_cycle(0, 1, 1, 0, 32'h20, 32'h10, 32'h24, (i >= 69995));
        end
        check_val("bc_saturated", 32'(bc0), 32'hFFFF);
        check_val("mc_saturated", 32'(mc1), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch predictor and resolver for the 5-stage RISC-V pipeline. It holds a PC-indexed table of saturating counters that the ID stage reads to predict conditional branches. At branch resolution it compares the actual outcome with the carried prediction, raises a flush with the corrected PC on a mismatch, trains the table, and keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- IDX_BITS, 4: table index width; table depth = 2^IDX_BITS entries.
- CTR_BITS, 2: counter width per entry; legal range 1..4.
- BYPASS, 0: 1 = a lookup that hits the entry being updated this cycle returns the post-update prediction; 0 = it returns the stored (pre-update) value.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- lookup_pc_i  input  32  PC of the branch in ID, used for prediction lookup.
- predict_o  output  1  prediction for lookup_pc_i; 1 = taken. Combinational.
- Branch_i  input  1  a conditional branch is resolving this cycle.
- branch_result_i  input  1  actual outcome; 1 = taken.
- predict_i  input  1  prediction made earlier for the resolving branch.
- Imm_i  input  32  branch immediate, in halfword units.
- PC_i  input  32  PC of the resolving branch.
- Flush_o  output  1  mispredict; squash younger instructions. Combinational.
- PC_o  output  32  corrected fetch PC. Combinational.
- branch_count_o  output  16  resolved branches; saturating.
- mispredict_count_o  output  16  mispredicts; saturating.

## Operation
- Index: lookup index = lookup_pc_i[IDX_BITS+1:2]; update index = PC_i[IDX_BITS+1:2]. Aliasing is permitted.
- Prediction: predict_o = MSB of the indexed counter.
- Mispredict: mis = Branch_i & (branch_result_i != predict_i).
- Flush_o = mis & ~rst_i.
- Correction PC:
  - branch_result_i=1: PC_o = PC_i + (Imm_i << 1), modulo 2^32 (wraps; no overflow flag).
  - branch_result_i=0: PC_o = PC_i + 4, modulo 2^32.
  - PC_o is driven with this value every cycle, even when Flush_o=0. It is fully combinational and never latched.
- Training, at a clock edge with Branch_i=1 and rst_i=0:
  - Taken: the counter at the update index increments, saturating at 2^CTR_BITS-1.
  - Not taken: the counter decrements, saturating at 0.
  - Training happens whether or not the branch mispredicted.
- Statistics, at a clock edge with Branch_i=1:
  - branch_count_o increments, holding at 0xFFFF.
  - mispredict_count_o increments when mis=1, holding at 0xFFFF.
- Read-during-write, same cycle and same index:
  - BYPASS=0: predict_o shows the stored value.
  - BYPASS=1: predict_o shows the MSB of the value being written.
- Reset:
  - Every table entry is set to weakly-not-taken, 2^(CTR_BITS-1)-1. With CTR_BITS=1 this is 0.
  - Both statistics counters are cleared to 0.
  - Flush_o is forced to 0 while rst_i=1.
  - Reset takes priority over a coincident Branch_i. That branch is dropped, with no training and no counting.
- Branch_i=0 leaves all state unchanged. branch_result_i, predict_i and Imm_i are ignored.

## Timing
- Lookup latency is 0 cycles: predict_o follows lookup_pc_i combinationally from table state.
- Resolution latency is 0 cycles: Flush_o and PC_o are valid in the cycle Branch_i is asserted.
- A training update is visible to lookups from the next cycle onward. With BYPASS=1 it is also visible in the same cycle.
- Statistics outputs change one cycle after the resolving branch.
- There is no handshake and no backpressure. Each cycle with Branch_i=1 is exactly one branch. The pipeline must deassert Branch_i during stalls to avoid double-counting.
- A reset asserted mid-run reinitialises the full table within one clock edge.

## Test plan
- Reset, then lookup_pc_i=0x40 -> predict_o=0, both statistics = 0, Flush_o=0.
- PC_i=0x40, Imm_i=0x8, predict_i=0, branch_result_i=1, Branch_i=1 -> Flush_o=1, PC_o=0x50 in the same cycle. Next cycle: lookup 0x40 gives predict_o=1, mispredict_count_o=1, branch_count_o=1.
- Four taken updates on PC 0x40, then one not-taken -> counter goes 1→2→3→3→3→2 and predict_o stays 1 (saturation checked). Two more not-taken updates -> 0; a further one holds at 0.
- PC_i=0xFFFFFFFC, branch_result_i=0, predict_i=1 -> Flush_o=1, PC_o=0x00000000 (wrap). PC_i=0x100, Imm_i=0xFFFFFFFC, taken with predict_i=0 -> PC_o=0xF8.
- Same-cycle update and lookup on index 3 (PC 0x0C, counter at 1, taken) -> BYPASS=0 gives predict_o=0; BYPASS=1 gives predict_o=1.
- Assert rst_i together with a mispredicting Branch_i -> Flush_o=0 and no count. Drive 70000 consecutive mispredicts -> both statistics hold at 0xFFFF.
